// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I-style core: fetch handshake, opcode decode,
// immediate-format selection, memory handshake, writeback strobes and retire counter.
module multicycle_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [2:0]  imm_type_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_ack_i,
   input  logic        br_taken_i,
   output logic        pc_we_o,
   output logic [1:0]  pc_sel_o,
   output logic        rf_we_o,
   output logic [1:0]  wb_sel_o,
   output logic        alu_src_imm_o,
   output logic [2:0]  state_o,
   output logic        illegal_o,
   output logic [31:0] retired_o
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      K_R, K_I, K_LOAD, K_STORE, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR
   } kind_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [31:0] instr_q, instr_d;
   logic [2:0]  imm_type_q, imm_type_d;
   logic        illegal_q, illegal_d;
   logic [31:0] retired_q, retired_d;
   logic        rd_nz;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= FETCH;
         kind_q     <= K_I;
         instr_q    <= NOP_INSTR;
         imm_type_q <= 3'd1;
         illegal_q  <= 1'b0;
         retired_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         instr_q    <= instr_d;
         imm_type_q <= imm_type_d;
         illegal_q  <= illegal_d;
         retired_q  <= retired_d;
      end
   end

   assign rd_nz = (instr_q[11:7] != 5'd0);

   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      instr_d       = instr_q;
      imm_type_d    = imm_type_q;
      illegal_d     = illegal_q;
      imem_req_o    = 1'b0;
      dmem_req_o    = 1'b0;
      dmem_we_o     = 1'b0;
      pc_we_o       = 1'b0;
      pc_sel_o      = 2'd0;
      rf_we_o       = 1'b0;
      wb_sel_o      = 2'd0;
      alu_src_imm_o = 1'b0;

      // Immediate-operand select holds from EXEC until the instruction ends.
      if ((state_q == EXEC) || (state_q == MEM) || (state_q == WB))
         alu_src_imm_o = (kind_q != K_R) && (kind_q != K_BR);

      unique case (state_q)
         FETCH: begin
            // Gated by rst_ni so the request drops the instant reset asserts.
            imem_req_o = rst_ni;
            if (imem_rvalid_i) begin
               instr_d = imem_rdata_i;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = EXEC;
            unique case (instr_q[6:0])
               7'b0110011: begin kind_d = K_R;     imm_type_d = 3'd0; end
               7'b0010011: begin kind_d = K_I;     imm_type_d = 3'd1; end
               7'b0000011: begin kind_d = K_LOAD;  imm_type_d = 3'd1; end
               7'b0100011: begin kind_d = K_STORE; imm_type_d = 3'd2; end
               7'b1100011: begin kind_d = K_BR;    imm_type_d = 3'd3; end
               7'b0110111: begin kind_d = K_LUI;   imm_type_d = 3'd4; end
               7'b0010111: begin kind_d = K_AUIPC; imm_type_d = 3'd4; end
               7'b1101111: begin kind_d = K_JAL;   imm_type_d = 3'd5; end
               7'b1100111: begin kind_d = K_JALR;  imm_type_d = 3'd1; end
               default: begin
                  imm_type_d = 3'd7;
                  illegal_d  = 1'b1;
                  state_d    = TRAP;
               end
            endcase
         end
         EXEC: begin
            if (kind_q == K_BR) begin
               pc_we_o  = 1'b1;
               pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
               state_d  = FETCH;
            end else if ((kind_q == K_LOAD) || (kind_q == K_STORE)) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = (kind_q == K_STORE);
            if (dmem_ack_i) begin
               if (kind_q == K_STORE) begin
                  pc_we_o = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            pc_we_o = 1'b1;
            rf_we_o = rd_nz;
            state_d = FETCH;
            unique case (kind_q)
               K_LOAD:         wb_sel_o = 2'd1;
               K_JAL, K_JALR:  wb_sel_o = 2'd2;
               K_LUI:          wb_sel_o = 2'd3;
               default:        wb_sel_o = 2'd0;
            endcase
            if (kind_q == K_JAL)
               pc_sel_o = 2'd1;
            else if (kind_q == K_JALR)
               pc_sel_o = 2'd2;
         end
         TRAP: state_d = TRAP;
         default: state_d = FETCH;
      endcase

      retired_d = retired_q + {31'd0, pc_we_o};
   end

   assign instr_o    = instr_q;
   assign imm_type_o = imm_type_q;
   assign state_o    = state_q;
   assign illegal_o  = illegal_q;
   assign retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction is summarised
// (latency, strobe counts, selects) and compared against per-format rules.
module tb_multicycle_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        imem_req_o;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'd0;
   logic [31:0] instr_o;
   logic [2:0]  imm_type_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic        dmem_ack_i = 1'b0;
   logic        br_taken_i = 1'b0;
   logic        pc_we_o;
   logic [1:0]  pc_sel_o;
   logic        rf_we_o;
   logic [1:0]  wb_sel_o;
   logic        alu_src_imm_o;
   logic [2:0]  state_o;
   logic        illegal_o;
   logic [31:0] retired_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_retired = 32'd0;

   multicycle_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .imem_req_o(imem_req_o), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instr_o(instr_o), .imm_type_o(imm_type_o),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
      .br_taken_i(br_taken_i), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
      .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .alu_src_imm_o(alu_src_imm_o),
      .state_o(state_o), .illegal_o(illegal_o), .retired_o(retired_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      imem_rvalid_i = 1'b0;
      dmem_ack_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      exp_retired = 32'd0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_state"}, {29'd0, state_o}, 32'd0);
      check({tag, "_instr"}, instr_o, 32'h0000_0013);
      check({tag, "_imm"}, {29'd0, imm_type_o}, 32'd1);
      check({tag, "_illegal"}, {31'd0, illegal_o}, 32'd0);
      check({tag, "_retired"}, retired_o, 32'd0);
      check({tag, "_strobes"}, {26'd0, pc_we_o, rf_we_o, dmem_req_o, dmem_we_o, pc_sel_o}, 32'd0);
   endtask

   // Runs one legal instruction and compares its summary with the format rules.
   task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait,
                            input logic taken);
      int exp_imm, exp_lat, exp_wb, exp_psel, exp_alu;
      bit wr, is_mem, is_st;
      int cyc, n_pc, n_rf, n_dm, n_dwe, obs_wb, obs_psel, obs_imm, obs_alu;
      int fw, mw;
      bit done;
      wr = 0; is_mem = 0; is_st = 0; exp_wb = 0; exp_psel = 0; exp_alu = 1; exp_lat = 4;
      exp_imm = 0;
      case (ins[6:0])
         7'b0110011: begin exp_imm = 0; wr = 1; exp_alu = 0; end
         7'b0010011: begin exp_imm = 1; wr = 1; end
         7'b0000011: begin exp_imm = 1; wr = 1; exp_wb = 1; is_mem = 1; exp_lat = 5; end
         7'b0100011: begin exp_imm = 2; is_mem = 1; is_st = 1; end
         7'b1100011: begin exp_imm = 3; exp_alu = 0; exp_lat = 3; exp_psel = taken ? 1 : 0; end
         7'b0110111: begin exp_imm = 4; wr = 1; exp_wb = 3; end
         7'b0010111: begin exp_imm = 4; wr = 1; end
         7'b1101111: begin exp_imm = 5; wr = 1; exp_wb = 2; exp_psel = 1; end
         7'b1100111: begin exp_imm = 1; wr = 1; exp_wb = 2; exp_psel = 2; end
         default: ;
      endcase
      exp_lat += fwait + (is_mem ? mwait : 0);
      if (ins[11:7] == 5'd0) wr = 0;

      cyc = 0; n_pc = 0; n_rf = 0; n_dm = 0; n_dwe = 0; obs_wb = -1; obs_psel = -1;
      obs_imm = -1; obs_alu = -1; fw = fwait; mw = mwait; done = 0;
      imem_rdata_i = ins;
      br_taken_i = taken;
      while (!done && cyc < 200) begin
         @(negedge clk_i);
         if (imem_req_o) begin
            imem_rvalid_i = (fw == 0);
            if (fw > 0) fw--;
         end else imem_rvalid_i = 1'($urandom_range(0, 1));
         if (dmem_req_o) begin
            dmem_ack_i = (mw == 0);
            if (mw > 0) mw--;
         end else dmem_ack_i = 1'($urandom_range(0, 1));
         #1;
         cyc++;
         if (state_o == 3'd2) begin
            obs_imm = int'(imm_type_o);
            obs_alu = int'(alu_src_imm_o);
         end
         if (dmem_req_o) n_dm++;
         if (dmem_req_o && dmem_we_o) n_dwe++;
         if (rf_we_o) begin n_rf++; obs_wb = int'(wb_sel_o); end
         if (pc_we_o) begin
            n_pc++;
            obs_psel = int'(pc_sel_o);
            done = 1;
         end
      end
      check("latency", cyc, exp_lat);
      check("imm_type", obs_imm, exp_imm);
      check("alu_src_imm", obs_alu, exp_alu);
      check("pc_we_count", n_pc, 1);
      check("pc_sel", obs_psel, exp_psel);
      check("rf_we_count", n_rf, wr ? 1 : 0);
      if (wr) check("wb_sel", obs_wb, exp_wb);
      check("dmem_req_cycles", n_dm, is_mem ? mwait + 1 : 0);
      check("dmem_we_cycles", n_dwe, is_st ? mwait + 1 : 0);
      exp_retired = exp_retired + 32'd1;
      @(posedge clk_i);
      #1;
      check("retired", retired_o, exp_retired);
      check("back_to_fetch", {29'd0, state_o}, 32'd0);
   endtask

   logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

   initial begin
      int seen, strobes;
      logic [31:0] r;
      #12;
      check_reset_state("reset_hold");
      check("reset_imem_req", {31'd0, imem_req_o}, 32'd0);
      do_reset();
      #1;
      check("post_reset_imem_req", {31'd0, imem_req_o}, 32'd1);

      run_instr(32'h0050_0093, 0, 0, 1'b0);
      run_instr(32'h0020_8463, 0, 0, 1'b1);
      run_instr(32'h0000_A183, 0, 3, 1'b0);

      // Preload the counter just below wrap, then retire a lui x0.
      @(negedge clk_i);
      imem_rvalid_i = 1'b0;
      force dut.retired_q = 32'hFFFF_FFFF;
      @(posedge clk_i);
      @(negedge clk_i);
      release dut.retired_q;
      #1;
      check("force_preload", retired_o, 32'hFFFF_FFFF);
      exp_retired = 32'hFFFF_FFFF;
      run_instr(32'h0000_0037, 0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         run_instr({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset while a store waits for its ack.
      do_reset();
      imem_rdata_i = 32'h0020_A023;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk_i);
         imem_rvalid_i = imem_req_o;
         dmem_ack_i = 1'b0;
         #1;
         if (dmem_req_o) seen = 1;
      end
      check("store_reached_mem", seen, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid_store_dmem_req", {31'd0, dmem_req_o}, 32'd0);
      check_reset_state("mid_store");
      @(negedge clk_i);
      rst_ni = 1'b1;
      imem_rvalid_i = 1'b0;
      #1;
      check("mid_store_refetch", {31'd0, imem_req_o}, 32'd1);

      // Illegal opcode traps until reset.
      imem_rdata_i = 32'h0000_007F;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge clk_i);
         imem_rvalid_i = imem_req_o;
         #1;
         if (state_o == 3'd5) seen = 1;
      end
      check("trap_state", seen, 1);
      check("trap_illegal", {31'd0, illegal_o}, 32'd1);
      check("trap_imm", {29'd0, imm_type_o}, 32'd7);
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         imem_rvalid_i = 1'($urandom_range(0, 1));
         dmem_ack_i = 1'($urandom_range(0, 1));
         #1;
         if (pc_we_o || rf_we_o || dmem_req_o || imem_req_o || state_o != 3'd5) strobes++;
      end
      check("trap_quiet", strobes, 0);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_reset_state("trap_clear");
      @(negedge clk_i);
      rst_ni = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
